// File: rtl/gray_pkg.sv
// Shared helpers for Gray-coded dual-clock FIFO pointers.
// Conversions work on a fixed maximum width; callers zero-extend in and truncate out.
package gray_pkg;

  localparam int unsigned MODE_RD  = 0;
  localparam int unsigned MODE_WR  = 1;
  localparam int unsigned GrayMaxW = 32;

  function automatic logic [GrayMaxW-1:0] bin2gray(input logic [GrayMaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros above the real width leave the low bits unaffected.
  function automatic logic [GrayMaxW-1:0] gray2bin(input logic [GrayMaxW-1:0] g);
    logic [GrayMaxW-1:0] b;
    b[GrayMaxW-1] = g[GrayMaxW-1];
    for (int i = GrayMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Reset-to-zero flop chain bringing a Gray pointer into the local clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// One side of a dual-clock FIFO: local binary/Gray pointer, remote pointer
// synchroniser, registered full (write side) or empty (read side) flag and fill level.
module gray_fifo_ptr
  import gray_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_RD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   gray,
  output logic              flag,
  output logic [ADDR_W:0]   level,
  output logic              err
);

  localparam int unsigned PtrW     = ADDR_W + 1;
  localparam logic        FlagRst  = (MODE == MODE_RD);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_fifo_ptr: SYNC_STAGES must be 2..4");
  end
  if (ADDR_W < 2) begin : g_bad_addr
    $error("gray_fifo_ptr: ADDR_W must be at least 2");
  end

  logic [ADDR_W:0] bin_q, bin_d;
  logic [ADDR_W:0] gray_q, gray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic [ADDR_W:0] rsync, rbin, rsync_full;
  logic            flag_q, flag_d;
  logic            err_q;
  logic            adv;

  gray_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_gray),
    .q   (rsync)
  );

  always_comb begin
    adv    = inc & ~flag_q;
    bin_d  = bin_q + {{ADDR_W{1'b0}}, adv};
    gray_d = PtrW'(bin2gray(GrayMaxW'(bin_d)));
    rbin   = PtrW'(gray2bin(GrayMaxW'(rsync)));
    // Full when the local pointer is exactly one lap ahead of the remote one.
    rsync_full = {~rsync[ADDR_W -: 2], rsync[ADDR_W-2:0]};
    if (MODE == MODE_WR) begin
      flag_d  = (gray_d == rsync_full);
      level_d = bin_d - rbin;
    end else begin
      flag_d  = (gray_d == rsync);
      level_d = rbin - bin_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      flag_q  <= FlagRst;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      flag_q  <= flag_d;
      level_q <= level_d;
      err_q   <= inc & flag_q;
    end
  end

  assign addr  = bin_q[ADDR_W-1:0];
  assign gray  = gray_q;
  assign flag  = flag_q;
  assign level = level_q;
  assign err   = err_q;

endmodule

// File: doc/gray_fifo_ptr.md
Name: gray_fifo_ptr

Overview:
- Parametrised Gray-coded pointer generator for one side of a dual-clock FIFO, such as the DSI pixel/command FIFOs.
- Keeps a binary address plus wrap bit and a glitch-free registered Gray pointer for export to the other clock domain.
- Synchronises the opposite side's Gray pointer and produces the registered full or empty flag, plus a fill level.
- One instance sits in the write domain (MODE=1) and one in the read domain (MODE=0).

Parameters:
- ADDR_W, 4, FIFO address bits; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flop stages on the remote pointer; legal 2..4.
- MODE, 0, 0 = read side (flag = empty), 1 = write side (flag = full).

Ports:
- clk  in  1  local domain clock
- rst  in  1  asynchronous active-low reset
- inc  in  1  request to advance pointer (push for MODE=1, pop for MODE=0)
- remote_gray  in  ADDR_W+1  Gray pointer from the opposite domain, asynchronous to clk
- addr  out  ADDR_W  binary RAM address, low bits of the local binary pointer
- gray  out  ADDR_W+1  registered Gray pointer for export
- flag  out  1  registered full (MODE=1) or empty (MODE=0)
- level  out  ADDR_W+1  registered occupancy: entries stored (MODE=1) or entries available (MODE=0)
- err  out  1  one-cycle pulse when inc is refused because flag=1

Behaviour:
- Reset (rst low, asynchronous) forces:
  - binary pointer = 0, gray = 0, all sync stages = 0, level = 0, err = 0.
  - flag = 1 when MODE=0 (empty); flag = 0 when MODE=1 (not full).
- Advance rule:
  - adv = inc & ~flag.
  - bin_next = bin + adv, modulo 2^(ADDR_W+1); wraps from all-ones to 0 with no special action.
  - gray_next = bin_next ^ (bin_next >> 1), computed combinationally and registered into gray. gray is always a flop output and changes at most one bit per cycle.
- err: registered, equals inc & flag from the previous cycle; held high for one cycle per refused request. A refused inc does not change bin, gray or level.
- Synchroniser:
  - remote_gray passes through SYNC_STAGES flops, all reset to 0; rsync is the last stage.
  - rbin = Gray-to-binary of rsync (MSB passes through, each lower bit is the XOR of all higher bits).
- Flag, registered and computed from gray_next and rsync:
  - MODE=0: flag <= (gray_next == rsync).
  - MODE=1: flag <= (gray_next == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]}).
- Level, registered, ADDR_W+1 bits, modulo arithmetic:
  - MODE=1: level <= bin_next - rbin.
  - MODE=0: level <= rbin - bin_next.
  - Range is 0..2^ADDR_W.
- Latency:
  - Local inc to updated gray, addr, flag and level: 1 cycle (same edge).
  - remote_gray change to flag/level update: SYNC_STAGES+1 cycles.
- Simultaneous events: a local advance and a remote change in the same cycle are both reflected, because bin_next and rsync are combined at the same edge.
- Pessimism: flag may stay asserted up to SYNC_STAGES+1 cycles after the remote side frees space or data. It never deasserts early.
- Reset mid-operation: all state returns to its reset values immediately. The remote domain must also be reset; the block does not coordinate this.
- Flag timing: no combinational path from inc to flag; flag depends only on registered state and rsync.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(width-generic);
  - function gray2bin(width-generic);
  - constants MODE_RD=0, MODE_WR=1.
- Sub-module gray_sync (WIDTH, STAGES): reset-to-zero flop chain, instantiated once for remote_gray.

Test Plan:
1. Reset:
   - MODE=0, ADDR_W=4: release rst -> flag=1, gray=0, level=0, err=0.
   - MODE=1: flag=0 after reset.
2. Gray sequence:
   - MODE=1, remote_gray held 0, inc high 16 cycles -> gray steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
   - flag=1 on the cycle gray=0x18; level=16.
   - A 17th inc -> err pulses 1 cycle; gray, addr and level stay unchanged.
3. Remote drain:
   - Continue from scenario 2 with remote_gray set to 0x01 -> flag drops exactly 3 cycles later (SYNC_STAGES=2); level=15.
4. Empty side:
   - MODE=0, remote_gray driven 0,1,3 on successive cycles -> level reaches 2 after the sync latency, flag=0.
   - Two incs -> flag=1, level=0; a third inc -> err pulse.
5. Wrap-around:
   - MODE=1 with remote following local (remote_gray = local gray delayed by 4 cycles), inc held high for 40 cycles.
   - bin wraps 31->0, gray goes 0x10->0x00, no spurious full; each cycle's gray differs from the previous one in at most 1 bit.
6. Reset mid-operation:
   - Assert rst asynchronously mid-cycle at level=7 -> all outputs take reset values before the next clk edge.
   - Counting resumes from gray=0 after release.
